// File: rtl/dcache_ctrl.sv
// Direct-mapped write-back / write-allocate data cache between the MEM stage and a line-wide memory.
// Hits are served combinationally; misses stall the pipeline while the victim is evicted and the line refilled.
//
// state     | meaning
// IDLE      | serve hits, detect misses
// WRITEBACK | dirty victim line being written to memory
// ALLOCATE  | missing line being fetched from memory
// UPDATE    | fill line installed; access re-evaluates next cycle
module dcache_ctrl #(
    parameter int NUM_LINES = 16
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         cpu_req_i,
    input  logic         cpu_we_i,
    input  logic [31:0]  cpu_addr_i,
    input  logic [31:0]  cpu_data_i,
    output logic [31:0]  cpu_data_o,
    output logic         cpu_stall_o,
    output logic         mem_req_o,
    output logic         mem_we_o,
    output logic [31:0]  mem_addr_o,
    output logic [255:0] mem_data_o,
    input  logic [255:0] mem_data_i,
    input  logic         mem_ack_i
);
    localparam int IW = $clog2(NUM_LINES);
    localparam int TW = 27 - IW;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WRITEBACK,
        S_ALLOCATE,
        S_UPDATE
    } state_t;

    state_t r_state, w_next;

    logic [NUM_LINES-1:0] r_valid;
    logic [NUM_LINES-1:0] r_dirty;
    logic [TW-1:0]        r_tag  [NUM_LINES];
    logic [255:0]         r_data [NUM_LINES];

    logic [TW-1:0]  r_miss_tag;
    logic [IW-1:0]  r_miss_idx;
    logic [255:0]   r_fill;
    logic [31:0]    r_mem_addr;
    logic [255:0]   r_mem_data;

    logic [IW-1:0]  w_idx;
    logic [TW-1:0]  w_tag;
    logic [2:0]     w_word;
    logic           w_idle;
    logic           w_hit;
    logic           w_miss;
    logic           w_victim_dirty;
    logic           w_unused;

    assign w_idx          = cpu_addr_i[4+IW:5];
    assign w_tag          = cpu_addr_i[31:5+IW];
    assign w_word         = cpu_addr_i[4:2];
    assign w_unused       = ^cpu_addr_i[1:0];
    assign w_idle         = (r_state == S_IDLE);
    assign w_hit          = w_idle & cpu_req_i & r_valid[w_idx] & (r_tag[w_idx] == w_tag);
    assign w_miss         = w_idle & cpu_req_i & ~w_hit;
    assign w_victim_dirty = r_valid[w_idx] & r_dirty[w_idx];

    assign cpu_stall_o = w_miss | ~w_idle;
    assign cpu_data_o  = (w_hit & ~cpu_we_i) ? r_data[w_idx][{w_word, 5'b0} +: 32] : 32'd0;
    assign mem_req_o   = (r_state == S_WRITEBACK) | (r_state == S_ALLOCATE);
    assign mem_we_o    = (r_state == S_WRITEBACK);
    assign mem_addr_o  = r_mem_addr;
    assign mem_data_o  = r_mem_data;

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:      if (w_miss) w_next = w_victim_dirty ? S_WRITEBACK : S_ALLOCATE;
            S_WRITEBACK: if (mem_ack_i) w_next = S_ALLOCATE;
            S_ALLOCATE:  if (mem_ack_i) w_next = S_UPDATE;
            S_UPDATE:    w_next = S_IDLE;
            default:     w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state    <= S_IDLE;
            r_valid    <= '0;
            r_dirty    <= '0;
            r_miss_tag <= '0;
            r_miss_idx <= '0;
            r_fill     <= '0;
            r_mem_addr <= '0;
            r_mem_data <= '0;
        end else begin
            r_state <= w_next;
            case (r_state)
                S_IDLE: begin
                    if (w_hit && cpu_we_i) r_dirty[w_idx] <= 1'b1;
                    if (w_miss) begin
                        r_miss_tag <= w_tag;
                        r_miss_idx <= w_idx;
                        // Address and line are registered so they stay stable for the whole request
                        if (w_victim_dirty) begin
                            r_mem_addr <= {r_tag[w_idx], w_idx, 5'b0};
                            r_mem_data <= r_data[w_idx];
                        end else begin
                            r_mem_addr <= {w_tag, w_idx, 5'b0};
                        end
                    end
                end
                S_WRITEBACK: if (mem_ack_i) r_mem_addr <= {r_miss_tag, r_miss_idx, 5'b0};
                S_ALLOCATE:  if (mem_ack_i) r_fill <= mem_data_i;
                S_UPDATE: begin
                    r_valid[r_miss_idx] <= 1'b1;
                    r_dirty[r_miss_idx] <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    // Tag and data arrays carry no reset; valid bits qualify them.
    always_ff @(posedge clk_i) begin
        if (w_hit && cpu_we_i) r_data[w_idx][{w_word, 5'b0} +: 32] <= cpu_data_i;
        if (r_state == S_UPDATE) begin
            r_data[r_miss_idx] <= r_fill;
            r_tag[r_miss_idx]  <= r_miss_tag;
        end
    end
endmodule

// File: tb/tb_dcache_ctrl.sv
// Directed bench for dcache_ctrl: a memory responder checks expected requests from a scoreboard queue,
// and load results are queued when a load is issued and compared once the stall releases.
module tb_dcache_ctrl;
    logic         clk_i = 1'b0;
    logic         rst_i;
    logic         cpu_req_i, cpu_we_i;
    logic [31:0]  cpu_addr_i, cpu_data_i;
    logic [31:0]  cpu_data_o;
    logic         cpu_stall_o;
    logic         mem_req_o, mem_we_o;
    logic [31:0]  mem_addr_o;
    logic [255:0] mem_data_o;
    logic [255:0] mem_data_i;
    logic         mem_ack_i;

    dcache_ctrl #(.NUM_LINES(16)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .cpu_req_i(cpu_req_i), .cpu_we_i(cpu_we_i), .cpu_addr_i(cpu_addr_i), .cpu_data_i(cpu_data_i),
        .cpu_data_o(cpu_data_o), .cpu_stall_o(cpu_stall_o),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o),
        .mem_data_i(mem_data_i), .mem_ack_i(mem_ack_i)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic         we;
        logic [31:0]  addr;
        logic         chk_data;
        logic [255:0] data;
    } txn_t;

    txn_t         exp_mem[$];
    logic [31:0]  exp_load[$];
    logic [255:0] tb_mem [logic [31:0]];
    int           n_tests = 0;
    int           n_fail  = 0;
    bit           auto_resp = 1'b1;
    bit           stray_ack = 1'b0;
    int           ack_delay = 0;

    function automatic logic [255:0] pat(logic [31:0] a);
        logic [255:0] l;
        for (int w = 0; w < 8; w++) l[w*32 +: 32] = {a[15:0], 8'hA5, 8'(w)};
        return l;
    endfunction

    function automatic logic [255:0] mem_get(logic [31:0] a);
        return tb_mem.exists(a) ? tb_mem[a] : pat(a);
    endfunction

    function automatic logic [31:0] wsel(logic [255:0] l, logic [31:0] a);
        return l[{a[4:2], 5'b0} +: 32];
    endfunction

    task automatic check(string tag, logic [255:0] obs, logic [255:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic push_txn(logic we, logic [31:0] addr, logic chk, logic [255:0] data);
        txn_t t;
        t.we = we; t.addr = addr; t.chk_data = chk; t.data = data;
        exp_mem.push_back(t);
    endtask

    // Memory responder: compares each request against the scoreboard, then acks after ack_delay cycles
    initial begin : responder
        txn_t        t;
        logic [31:0] a;
        mem_ack_i  = 1'b0;
        mem_data_i = '0;
        forever begin
            @(negedge clk_i);
            mem_ack_i = stray_ack;
            if (auto_resp && rst_i && mem_req_o) begin
                if (exp_mem.size() == 0) begin
                    check("unexpected_mem_req", mem_req_o, 0);
                end else begin
                    t = exp_mem.pop_front();
                    check("mem_we", mem_we_o, t.we);
                    check("mem_addr", mem_addr_o, t.addr);
                    if (t.chk_data) check("wb_data", mem_data_o, t.data);
                    a = mem_addr_o;
                    for (int i = 0; i < ack_delay; i++) begin
                        @(negedge clk_i);
                        check("req_held", mem_req_o, 1);
                        check("addr_held", mem_addr_o, a);
                        check("stall_held", cpu_stall_o, 1);
                    end
                    if (mem_we_o) tb_mem[a] = mem_data_o;
                    else          mem_data_i = mem_get(a);
                    mem_ack_i = 1'b1;
                end
            end
        end
    end

    task automatic do_load(string tag, logic [31:0] addr, logic [31:0] exp_data, int exp_stalls);
        int stalls = 0;
        bit done = 1'b0;
        logic [31:0] e;
        exp_load.push_back(exp_data);
        cpu_req_i = 1'b1; cpu_we_i = 1'b0; cpu_addr_i = addr;
        for (int c = 0; c < 200 && !done; c++) begin
            @(negedge clk_i);
            if (!cpu_stall_o) done = 1'b1;
            else begin
                stalls++;
                @(posedge clk_i); #1;
            end
        end
        check({tag, "_done"}, done, 1);
        e = exp_load.pop_front();
        if (done) begin
            check({tag, "_data"}, cpu_data_o, e);
            check({tag, "_stalls"}, stalls, exp_stalls);
        end
        @(posedge clk_i); #1;
        cpu_req_i = 1'b0;
    endtask

    task automatic do_store(string tag, logic [31:0] addr, logic [31:0] data);
        cpu_req_i = 1'b1; cpu_we_i = 1'b1; cpu_addr_i = addr; cpu_data_i = data;
        @(negedge clk_i);
        check({tag, "_stall"}, cpu_stall_o, 0);
        check({tag, "_memreq"}, mem_req_o, 0);
        @(posedge clk_i); #1;
        cpu_req_i = 1'b0; cpu_we_i = 1'b0;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : main
        logic [255:0] l40, wb40;
        rst_i = 1'b0;
        cpu_req_i = 1'b0; cpu_we_i = 1'b0; cpu_addr_i = '0; cpu_data_i = '0;
        l40 = pat(32'h40);
        l40[63:32] = 32'hDEADBEEF;
        tb_mem[32'h40] = l40;
        wb40 = l40;
        wb40[63:32] = 32'h12345678;

        #12;
        check("rst_stall", cpu_stall_o, 0);
        check("rst_memreq", mem_req_o, 0);
        check("rst_memwe", mem_we_o, 0);
        check("rst_memaddr", mem_addr_o, 0);
        check("rst_memdata", mem_data_o, 0);
        check("rst_cpudata", cpu_data_o, 0);
        @(posedge clk_i); #1 rst_i = 1'b1;
        @(posedge clk_i); #1;

        push_txn(1'b0, 32'h40, 1'b0, '0);
        do_load("cold", 32'h44, 32'hDEADBEEF, 3);

        do_store("wr_hit", 32'h44, 32'h12345678);
        do_load("wr_hit_rd", 32'h44, 32'h12345678, 0);

        push_txn(1'b1, 32'h40, 1'b1, wb40);
        push_txn(1'b0, 32'h240, 1'b0, '0);
        do_load("dirty", 32'h244, wsel(pat(32'h240), 32'h244), 4);

        push_txn(1'b0, 32'h40, 1'b0, '0);
        do_load("clean_a", 32'h40, wsel(pat(32'h40), 32'h40), 3);
        push_txn(1'b0, 32'h240, 1'b0, '0);
        do_load("clean_b", 32'h240, wsel(pat(32'h240), 32'h240), 3);

        ack_delay = 10;
        push_txn(1'b0, 32'h440, 1'b0, '0);
        do_load("slow", 32'h444, wsel(pat(32'h440), 32'h444), 13);
        ack_delay = 0;

        auto_resp = 1'b0;
        cpu_req_i = 1'b1; cpu_we_i = 1'b0; cpu_addr_i = 32'h640;
        @(negedge clk_i);
        check("rmf_stall", cpu_stall_o, 1);
        @(posedge clk_i); #1;
        check("rmf_req_alloc", mem_req_o, 1);
        check("rmf_addr_alloc", mem_addr_o, 32'h640);
        #2 rst_i = 1'b0;
        #1;
        check("rmf_req_async", mem_req_o, 0);
        check("rmf_addr_async", mem_addr_o, 0);
        cpu_req_i = 1'b0;
        @(posedge clk_i); #1 rst_i = 1'b1;
        stray_ack = 1'b1;
        @(posedge clk_i); #1 stray_ack = 1'b0;
        @(negedge clk_i);
        check("stray_ack_req", mem_req_o, 0);
        check("stray_ack_stall", cpu_stall_o, 0);
        @(posedge clk_i); #1;
        auto_resp = 1'b1;
        push_txn(1'b0, 32'h440, 1'b0, '0);
        do_load("post_rst", 32'h444, wsel(pat(32'h440), 32'h444), 3);

        check("txn_queue_empty", exp_mem.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/dcache_ctrl.md
# dcache_ctrl

Direct-mapped, write-back, write-allocate data cache controller placed between the pipeline's MEM stage and a slow line-wide off-chip data memory. It serves single-word loads and stores from the MEM stage, combinationally on a hit, and stalls the pipeline while it evicts dirty lines and refills missing ones. It replaces the pipeline's single-cycle data memory port. The pipeline freezes all stage registers while `cpu_stall_o` is high.

## Interface
- `NUM_LINES`, 16: number of cache lines; power of two, 2 to 256.
- Line size is fixed at 32 bytes (256 bits, eight 32-bit words).

Ports:
- `clk_i` input 1: clock, all state on rising edge.
- `rst_i` input 1: reset, asynchronous and active-low.
- `cpu_req_i` input 1: MEM-stage access valid (MemRead or MemWrite).
- `cpu_we_i` input 1: 1 = store, 0 = load.
- `cpu_addr_i` input 32: byte address; bits [1:0] ignored.
- `cpu_data_i` input 32: store data.
- `cpu_data_o` output 32: load data, valid when `cpu_req_i`=1 and `cpu_stall_o`=0.
- `cpu_stall_o` output 1: pipeline stall.
- `mem_req_o` output 1: memory request, held until acknowledged.
- `mem_we_o` output 1: 1 = line write-back, 0 = line fill.
- `mem_addr_o` output 32: line-aligned address, bits [4:0]=0.
- `mem_data_o` output 256: write-back line data.
- `mem_data_i` input 256: fill data, valid in the `mem_ack_i` cycle.
- `mem_ack_i` input 1: one-cycle completion pulse.

## Operation
- Address split: offset [4:0]; word select [4:2]; index [4+IW:5] with IW = log2(NUM_LINES); tag [31:5+IW].
- Per-line storage: valid bit, dirty bit, tag, 256-bit data. Word w occupies line bits [32w+31:32w].
- Hit = `cpu_req_i` & valid[idx] & (tag[idx]==addr tag), evaluated in state IDLE only.
- States:
  - **IDLE**
    - Read hit: `cpu_data_o` = selected word, combinational.
    - Write hit: selected word <= `cpu_data_i`, dirty <= 1 at the clock edge.
    - Miss with victim valid and dirty: go to WRITEBACK.
    - Miss otherwise: go to ALLOCATE.
    - Miss request address and tag are latched at this transition.
  - **WRITEBACK**
    - `mem_req_o`=1, `mem_we_o`=1.
    - `mem_addr_o` = {victim tag, idx, 5'b0}; `mem_data_o` = victim line.
    - On `mem_ack_i`: go to ALLOCATE.
  - **ALLOCATE**
    - `mem_req_o`=1, `mem_we_o`=0, `mem_addr_o` = {latched tag, idx, 5'b0}.
    - On `mem_ack_i`: capture `mem_data_i` into a fill register; go to UPDATE.
  - **UPDATE**
    - Write the fill line, new tag, valid=1, dirty=0; go to IDLE.
    - The re-evaluated access then hits; a store performs its write there, setting dirty.
- `cpu_stall_o` = (IDLE & `cpu_req_i` & ~hit) | (state != IDLE).
- The state machine ignores `cpu_req_i` or address changes outside IDLE. A started transaction always completes, and the line is installed even if the request is withdrawn.
- Outputs driven outside active states:
  - `mem_req_o`=0, `mem_we_o`=0.
  - `mem_addr_o` and `mem_data_o` hold their last value.
  - `cpu_data_o`=0 when there is no read hit.
- Reset (`rst_i`=0, asynchronous, any state):
  - State goes to IDLE; all valid and dirty bits clear.
  - `mem_req_o`, `mem_we_o`, `mem_addr_o`, `mem_data_o`, `cpu_data_o` go to 0.
  - An in-flight memory transaction is abandoned, and its later ack is ignored in IDLE.
  - Tag and data arrays need no reset.

## Timing
- Hit: zero-latency. Stall stays low and load data is valid in the request cycle.
- Clean miss, ack in the first request cycle:
  - Cycle 0: IDLE, stall=1.
  - Cycle 1: ALLOCATE.
  - Cycle 2: UPDATE.
  - Cycle 3: IDLE hit, stall=0.
  - Minimum 3 stall cycles.
- Dirty miss: minimum 4 stall cycles. Each extra cycle of ack delay adds one stall cycle.
- `mem_req_o` rises the cycle after the miss is detected and stays stable until the ack cycle, inclusive. `mem_addr_o`, `mem_we_o` and `mem_data_o` are constant throughout.
- `mem_req_o` falls in the cycle after the ack. WRITEBACK→ALLOCATE re-asserts it immediately with the new address.
- `mem_ack_i` outside WRITEBACK/ALLOCATE is ignored.

## Test plan
- **Cold read miss:** after reset, load 0x0000_0044.
  - Stall=1; then `mem_req_o`=1, `mem_we_o`=0, `mem_addr_o`=0x40.
  - Ack with word 1 = 0xDEADBEEF → stall drops 3 cycles after the request, `cpu_data_o`=0xDEADBEEF.
- **Write hit:** store 0x12345678 to 0x44, then load 0x44.
  - No `mem_req_o` activity; zero stall; read returns 0x12345678.
- **Dirty conflict (NUM_LINES=16):** after the write hit above, load 0x244.
  - Write-back: `mem_we_o`=1, `mem_addr_o`=0x40, `mem_data_o`[63:32]=0x12345678.
  - Then fill: `mem_we_o`=0, `mem_addr_o`=0x240; load returns fill word 1.
- **Clean conflict:** load 0x40, then load 0x240.
  - Only a fill request appears, no write-back.
- **Slow memory:** ack delayed 10 cycles.
  - `cpu_stall_o` and `mem_req_o`/`mem_addr_o` held constant for all 10 cycles; completion as above.
- **Reset mid-fill:** assert `rst_i`=0 in ALLOCATE.
  - `mem_req_o` drops without waiting for a clock.
  - After release, a load to the previously filled address misses again, since valid was cleared.
